// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state encoding and ms-to-cycles helper for the button input chain.
package btn_pkg;

    typedef enum logic [2:0] {LOCKOUT, IDLE, PRESS1, GAP, LONG_HELD, WAIT_REL} state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_press_classifier.sv
// btn_press_classifier: turns a debounced button level into single/double/long/repeat pulses.
module btn_press_classifier
    import btn_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned LONG_MS   = 800,
    parameter int unsigned GAP_MS    = 250,
    parameter int unsigned REPEAT_MS = 150
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_stable,
    output logic single_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic busy
);

    localparam int unsigned LONG_CNT   = ms_to_cycles(CLK_HZ, LONG_MS);
    localparam int unsigned GAP_CNT    = ms_to_cycles(CLK_HZ, GAP_MS);
    localparam int unsigned REPEAT_CNT = ms_to_cycles(CLK_HZ, REPEAT_MS);
    localparam int unsigned MAX_LG     = LONG_CNT > GAP_CNT ? LONG_CNT : GAP_CNT;
    localparam int unsigned MAX_CNT    = MAX_LG > REPEAT_CNT ? MAX_LG : REPEAT_CNT;
    localparam int          CW         = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CNT - 1);
    localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CNT - 1);

    if (LONG_CNT < 2 || GAP_CNT < 2 || REPEAT_CNT < 2) begin : g_bad_params
        $error("btn_press_classifier: every derived cycle count must be at least 2");
    end

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          s_n, d_n, l_n, r_n;

    // cnt holds (edges since entering the state) - 1 when sampled, hence the *_LAST compares
    always_comb begin
        state_n = state;
        s_n = 1'b0;
        d_n = 1'b0;
        l_n = 1'b0;
        r_n = 1'b0;
        case (state)
            LOCKOUT:  state_n = btn_stable ? LOCKOUT : IDLE;
            IDLE:     state_n = btn_stable ? PRESS1 : IDLE;
            PRESS1: begin
                if (!btn_stable) state_n = GAP;
                else if (cnt == LONG_LAST) begin
                    state_n = LONG_HELD;
                    l_n = 1'b1;
                end
            end
            GAP: begin
                if (btn_stable) begin
                    state_n = WAIT_REL;
                    d_n = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    s_n = 1'b1;
                end
            end
            LONG_HELD: begin
                if (!btn_stable) state_n = IDLE;
                else r_n = cnt == RPT_LAST;
            end
            WAIT_REL: state_n = btn_stable ? WAIT_REL : IDLE;
            default:  state_n = LOCKOUT;
        endcase
    end

    // a repeat restarts the period, so it clears the counter like a state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOCKOUT;
            cnt          <= '0;
            single_pulse <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= (state_n != state || r_n) ? '0 : (&cnt ? cnt : cnt + 1'b1);
            single_pulse <= s_n;
            double_pulse <= d_n;
            long_pulse   <= l_n;
            repeat_pulse <= r_n;
            busy         <= state_n != IDLE;
        end
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
// tb_btn_press_classifier: scoreboard bench; tests queue expected pulses, a monitor pops and compares them.
module tb_btn_press_classifier;

    localparam logic [3:0] K_S = 4'b1000;
    localparam logic [3:0] K_D = 4'b0100;
    localparam logic [3:0] K_L = 4'b0010;
    localparam logic [3:0] K_R = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] kind;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_stable = 1'b1;
    logic single_pulse, double_pulse, long_pulse, repeat_pulse, busy;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] obs;
    int         cyc = 0;
    int         base = 0;
    int         checks = 0;
    int         passed = 0;

    btn_press_classifier #(
        .CLK_HZ(1000), .LONG_MS(5), .GAP_MS(3), .REPEAT_MS(2)
    ) dut (
        .clk(clk), .rst(rst), .btn_stable(btn_stable),
        .single_pulse(single_pulse), .double_pulse(double_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    // cyc equals n right after the nth rising edge; outputs sampled 1 ns later
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        obs = {single_pulse, double_pulse, long_pulse, repeat_pulse};
        if (obs != 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, obs);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.cyc !== cyc || mon_e.kind !== obs)
                    $display("FAIL pulse got cyc=%0d kind=%b required cyc=%0d kind=%b",
                             cyc, obs, mon_e.cyc, mon_e.kind);
                else passed++;
            end
        end
    end

    task automatic push(input int en, input logic [3:0] k);
        sb.push_back('{base + en, k});
    endtask

    task automatic drive(input int from, input int to, input int p1, input int r1,
                         input int p2, input int r2);
        for (int e = from; e < to; e++) begin
            btn_stable = (e >= p1 && e < r1) || (e >= p2 && e < r2);
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({single_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== 5'b0)
            $display("FAIL reset_outputs got=%b required=00000",
                     {single_pulse, double_pulse, long_pulse, repeat_pulse, busy});
        else passed++;
        rst = 1'b0;
        drive(0, 20, 0, 20, -1, -1);
        checks++;
        if (busy !== 1'b1) $display("FAIL lockout_busy got=%b required=1", busy);
        else passed++;
        base = cyc + 1;
        push(11, K_S);
        drive(0, 16, 5, 8, -1, -1);
        checks++;
        if (busy !== 1'b0) $display("FAIL after_lockout_busy got=%b required=0", busy);
        else passed++;
        checks++;
        if (sb.size() != 0) $display("FAIL after_lockout_missing got=%0d required=0", sb.size());
        else passed++;
    endtask

    task automatic test_single;
        base = cyc + 1;
        push(15, K_S);
        drive(0, 11, 10, 12, -1, -1);
        checks++;
        if (busy !== 1'b1) $display("FAIL single_busy_e10 got=%b required=1", busy);
        else passed++;
        drive(11, 15, 10, 12, -1, -1);
        checks++;
        if (busy !== 1'b1) $display("FAIL single_busy_e14 got=%b required=1", busy);
        else passed++;
        drive(15, 16, 10, 12, -1, -1);
        checks++;
        if (busy !== 1'b0) $display("FAIL single_busy_e15 got=%b required=0", busy);
        else passed++;
        drive(16, 20, 10, 12, -1, -1);
        checks++;
        if (sb.size() != 0) $display("FAIL single_missing got=%0d required=0", sb.size());
        else passed++;
    endtask

    task automatic test_double;
        base = cyc + 1;
        push(14, K_D);
        drive(0, 16, 10, 12, 14, 16);
        checks++;
        if (busy !== 1'b1) $display("FAIL double_busy_e15 got=%b required=1", busy);
        else passed++;
        drive(16, 17, 10, 12, 14, 16);
        checks++;
        if (busy !== 1'b0) $display("FAIL double_busy_e16 got=%b required=0", busy);
        else passed++;
        drive(17, 22, 10, 12, 14, 16);
        checks++;
        if (sb.size() != 0) $display("FAIL double_missing got=%0d required=0", sb.size());
        else passed++;
    endtask

    task automatic test_gap_tie;
        base = cyc + 1;
        push(15, K_D);
        drive(0, 22, 10, 12, 15, 17);
        checks++;
        if (sb.size() != 0) $display("FAIL gap_tie_missing got=%0d required=0", sb.size());
        else passed++;
    endtask

    task automatic test_gap_miss;
        base = cyc + 1;
        push(15, K_S);
        push(21, K_S);
        drive(0, 28, 10, 12, 16, 18);
        checks++;
        if (sb.size() != 0) $display("FAIL gap_miss_missing got=%0d required=0", sb.size());
        else passed++;
    endtask

    task automatic test_long_repeat;
        base = cyc + 1;
        push(15, K_L);
        push(17, K_R);
        push(19, K_R);
        drive(0, 21, 10, 21, -1, -1);
        checks++;
        if (busy !== 1'b1) $display("FAIL long_busy_e20 got=%b required=1", busy);
        else passed++;
        drive(21, 22, 10, 21, -1, -1);
        checks++;
        if (busy !== 1'b0) $display("FAIL long_busy_e21 got=%b required=0", busy);
        else passed++;
        drive(22, 28, 10, 21, -1, -1);
        checks++;
        if (sb.size() != 0) $display("FAIL long_missing got=%0d required=0", sb.size());
        else passed++;
    endtask

    task automatic test_reset_mid;
        base = cyc + 1;
        push(15, K_L);
        push(17, K_R);
        drive(0, 18, 10, 25, -1, -1);
        rst = 1'b1;
        #1;
        checks++;
        if ({single_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== 5'b0)
            $display("FAIL async_reset got=%b required=00000",
                     {single_pulse, double_pulse, long_pulse, repeat_pulse, busy});
        else passed++;
        drive(18, 21, 10, 25, -1, -1);
        rst = 1'b0;
        drive(21, 25, 10, 25, -1, -1);
        checks++;
        if (busy !== 1'b1) $display("FAIL mid_lockout_busy got=%b required=1", busy);
        else passed++;
        drive(25, 35, 10, 25, -1, -1);
        checks++;
        if (busy !== 1'b0) $display("FAIL mid_release_busy got=%b required=0", busy);
        else passed++;
        checks++;
        if (sb.size() != 0) $display("FAIL mid_missing got=%0d required=0", sb.size());
        else passed++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_double;
        test_gap_tie;
        test_gap_miss;
        test_long_repeat;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
